cv32e40p_regfile_wb_ctrl: RTL and testbench
===========================================

# cv32e40p_regfile_wb_ctrl

Write-back controller that owns the single write port of the integer register file. It merges an always-accepted EX-stage result stream and a handshaked LSU load-data stream into one registered write (waddr/wdata/we) per cycle. A small LSU skid FIFO absorbs loads that lose arbitration to EX. A 32-bit pending-load scoreboard lets the decode stage stall on registers with an outstanding load.

## Interface
- LSU_FIFO_DEPTH, 2, number of LSU results buffered when EX wins arbitration (≥1).
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_we_i  in  1  EX result valid this cycle; never back-pressured
- ex_waddr_i  in  5  EX destination register
- ex_wdata_i  in  32  EX result
- lsu_valid_i  in  1  LSU load data valid
- lsu_ready_o  out  1  LSU data accepted when valid & ready; = FIFO not full (combinational)
- lsu_waddr_i  in  5  load destination register
- lsu_wdata_i  in  32  load data
- issue_load_i  in  1  a load is being issued to the LSU this cycle
- issue_load_addr_i  in  5  destination of the issued load
- busy_o  out  32  bit r = register r has an outstanding load; bit 0 constant 0
- waddr_a_o  out  5  register-file write address (registered)
- wdata_a_o  out  32  register-file write data (registered)
- we_a_o  out  1  register-file write enable (registered)
- wb_src_o  out  1  source of current write: 0 = EX, 1 = LSU (registered)

## Operation
- Per cycle, the arbiter selects at most one candidate, in this priority order:
  1. EX, if ex_we_i = 1.
  2. Otherwise the FIFO head, if the FIFO is non-empty.
  3. Otherwise LSU bypass, if lsu_valid_i & lsu_ready_o and the FIFO is empty.
- Accepted LSU data not consumed by bypass is pushed to the FIFO tail.
- Push and pop in the same cycle are legal; with a full FIFO this makes lsu_ready_o = 0 that cycle (ready is not pop-aware).
- LSU results always commit in acceptance order. Bypass never overtakes FIFO contents.
- A selected candidate with address 0 is consumed, but we_a_o = 0 for that cycle (x0 is never written). waddr/wdata still update.
- No candidate selected: we_a_o = 0; waddr_a_o, wdata_a_o and wb_src_o hold their values.
- Scoreboard:
  - Set: issue_load_i with addr ≠ 0 sets busy[addr].
  - Clear: the cycle an LSU-sourced write to addr is launched (selected, so we_a_o rises next edge), busy[addr] clears at that same edge.
  - Set and clear of the same addr in one cycle: set wins.
  - EX writes never touch the scoreboard.
- Hazards are not checked. Decode must stall EX writes and new loads to any register with busy_o set. If EX and LSU target the same register, the final value is whichever commits last per the priority rules.

## Timing
- Reset (async assert, sync-to-clk deassert by system): we_a_o = 0, waddr_a_o = 0, wdata_a_o = 0, wb_src_o = 0, busy_o = 0, FIFO empty, so lsu_ready_o = 1.
- Reset mid-operation discards FIFO contents and the scoreboard. No write is emitted for discarded entries.
- EX latency: ex_we_i at edge N → we_a_o/waddr/wdata valid after edge N+1, for exactly one cycle.
- LSU latency: 1 cycle via bypass. Otherwise 1 cycle + number of cycles EX occupies the port + FIFO entries ahead.
- Throughput: one write per cycle. Continuous ex_we_i starves the LSU; the FIFO fills and lsu_ready_o drops.
- busy_o is registered: a set is visible the cycle after issue_load_i; a clear is visible the same cycle we_a_o shows the LSU write.
- FIFO pointers wrap modulo LSU_FIFO_DEPTH. Occupancy counter width is clog2(DEPTH+1).

## Test plan
- Reset: hold rst_n = 0 with random inputs → all outputs 0, lsu_ready_o = 1; release, idle 3 cycles → we_a_o stays 0.
- EX only: ex_we_i with x5 = 0xDEADBEEF → one cycle later we_a_o = 1, waddr_a_o = 5, wdata_a_o = 0xDEADBEEF, wb_src_o = 0. An x0 write gives we_a_o = 0.
- Load round trip: issue_load to x7 → busy_o[7] = 1 next cycle. LSU x7 = 0x12345678 with no EX → write after 1 cycle with wb_src_o = 1, and busy_o[7] clears in the same cycle.
- Contention: three EX writes (x1, x2, x3) back-to-back while LSU presents x10 = 0xA, x11 = 0xB, x12 = 0xC.
  - FIFO (depth 2) fills after x10 and x11; lsu_ready_o = 0 while x12 waits.
  - Write order: x1, x2, x3, x10, x11, x12.
  - No LSU data is lost or reordered.
- Scoreboard corner cases:
  - Re-issue a load to x9 in the same cycle its previous LSU write is selected → busy_o[9] remains 1.
  - issue_load to x0 → busy_o[0] stays 0.
- Async reset with 2 FIFO entries pending → FIFO emptied; no write emitted for those entries after release; busy_o = 0.

Source files
------------

// File: rtl/cv32e40p_regfile_wb_ctrl.sv
// Register-file write-back controller: merges EX results and LSU load data
// onto a single registered write port, with a load skid FIFO and scoreboard.
module cv32e40p_regfile_wb_ctrl #(
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_we_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        issue_load_i,
  input  logic [4:0]  issue_load_addr_i,
  output logic [31:0] busy_o,
  output logic [4:0]  waddr_a_o,
  output logic [31:0] wdata_a_o,
  output logic        we_a_o,
  output logic        wb_src_o
);

  localparam int D  = LSU_FIFO_DEPTH;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [4:0]    f_addr [D];
  logic [31:0]   f_data [D];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic        empty, accept;
  logic        sel_ex, sel_fifo, sel_byp, sel_any, sel_lsu;
  logic        push, pop;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic [31:0] busy_next;

  assign empty       = (count == '0);
  assign lsu_ready_o = (count != CW'(D));
  assign accept      = lsu_valid_i & lsu_ready_o;

  assign sel_ex   = ex_we_i;
  assign sel_fifo = !ex_we_i && !empty;
  assign sel_byp  = !ex_we_i && empty && accept;
  assign sel_lsu  = sel_fifo | sel_byp;
  assign sel_any  = sel_ex | sel_lsu;

  assign push = accept & !sel_byp;
  assign pop  = sel_fifo;

  always_comb begin
    sel_addr = lsu_waddr_i;
    sel_data = lsu_wdata_i;
    unique case (1'b1)
      sel_ex:   begin sel_addr = ex_waddr_i;     sel_data = ex_wdata_i;     end
      sel_fifo: begin sel_addr = f_addr[rd_ptr]; sel_data = f_data[rd_ptr]; end
      default:  ;
    endcase
  end

  // Set beats clear when a load is re-issued to the register being retired.
  always_comb begin
    busy_next = busy_o;
    if (sel_lsu)
      busy_next[sel_addr] = 1'b0;
    if (issue_load_i && issue_load_addr_i != 5'd0)
      busy_next[issue_load_addr_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < D; i++) begin
        f_addr[i] <= '0;
        f_data[i] <= '0;
      end
    end else begin
      if (push) begin
        f_addr[wr_ptr] <= lsu_waddr_i;
        f_data[wr_ptr] <= lsu_wdata_i;
        wr_ptr <= (wr_ptr == PW'(D - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PW'(D - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      we_a_o    <= 1'b0;
      wb_src_o  <= 1'b0;
      busy_o    <= '0;
    end else begin
      busy_o <= busy_next;
      we_a_o <= sel_any && (sel_addr != 5'd0);
      if (sel_any) begin
        waddr_a_o <= sel_addr;
        wdata_a_o <= sel_data;
        wb_src_o  <= sel_lsu;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_regfile_wb_ctrl.sv
// Directed self-checking bench for the write-back controller.
module tb_cv32e40p_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        issue_load_i;
  logic [4:0]  issue_load_addr_i;
  logic [31:0] busy_o;
  logic [4:0]  waddr_a_o;
  logic [31:0] wdata_a_o;
  logic        we_a_o;
  logic        wb_src_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cv32e40p_regfile_wb_ctrl #(.LSU_FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .issue_load_i(issue_load_i), .issue_load_addr_i(issue_load_addr_i),
    .busy_o(busy_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_a_o(we_a_o), .wb_src_o(wb_src_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    lsu_valid_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
    issue_load_i = 0; issue_load_addr_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      ex_we_i = 1'($urandom); ex_waddr_i = 5'($urandom);
      ex_wdata_i = $urandom; lsu_valid_i = 1'($urandom);
      lsu_waddr_i = 5'($urandom); lsu_wdata_i = $urandom;
      issue_load_i = 1'($urandom); issue_load_addr_i = 5'($urandom);
      cyc();
      checks++;
      if ({we_a_o, waddr_a_o, wdata_a_o, wb_src_o, busy_o} !== '0
          || lsu_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL reset_state: we=%b waddr=%0d wdata=%h src=%b busy=%h ready=%b, expected all 0 ready=1",
                 we_a_o, waddr_a_o, wdata_a_o, wb_src_o, busy_o, lsu_ready_o);
      end
    end
    idle_inputs();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (we_a_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: we=%b expected 0", we_a_o);
      end
    end
  endtask

  task automatic test_ex_write();
    ex_we_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hDEADBEEF;
    cyc();
    ex_we_i = 0;
    checks++;
    if (we_a_o !== 1 || waddr_a_o !== 5 || wdata_a_o !== 32'hDEADBEEF || wb_src_o !== 0) begin
      errors++;
      $display("FAIL ex_write: we=%b waddr=%0d wdata=%h src=%b, expected 1 5 deadbeef 0",
               we_a_o, waddr_a_o, wdata_a_o, wb_src_o);
    end
    cyc();
    checks++;
    if (we_a_o !== 0 || waddr_a_o !== 5 || wdata_a_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ex_hold: we=%b waddr=%0d wdata=%h, expected 0 5 deadbeef",
               we_a_o, waddr_a_o, wdata_a_o);
    end
    ex_we_i = 1; ex_waddr_i = 0; ex_wdata_i = 32'h00001234;
    cyc();
    ex_we_i = 0;
    checks++;
    if (we_a_o !== 0 || waddr_a_o !== 0 || wdata_a_o !== 32'h00001234) begin
      errors++;
      $display("FAIL ex_x0: we=%b waddr=%0d wdata=%h, expected 0 0 00001234",
               we_a_o, waddr_a_o, wdata_a_o);
    end
  endtask

  task automatic test_load_round_trip();
    issue_load_i = 1; issue_load_addr_i = 7;
    cyc();
    issue_load_i = 0;
    checks++;
    if (busy_o !== 32'h0000_0080) begin
      errors++;
      $display("FAIL load_busy_set: busy=%h expected 00000080", busy_o);
    end
    lsu_valid_i = 1; lsu_waddr_i = 7; lsu_wdata_i = 32'h12345678;
    cyc();
    lsu_valid_i = 0;
    checks++;
    if (we_a_o !== 1 || waddr_a_o !== 7 || wdata_a_o !== 32'h12345678
        || wb_src_o !== 1 || busy_o !== 0) begin
      errors++;
      $display("FAIL load_write: we=%b waddr=%0d wdata=%h src=%b busy=%h, expected 1 7 12345678 1 0",
               we_a_o, waddr_a_o, wdata_a_o, wb_src_o, busy_o);
    end
  endtask

  task automatic test_contention();
    logic       t_ex  [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic [4:0] t_exa [7] = '{1, 2, 3, 0, 0, 0, 0};
    logic       t_lv  [7] = '{1, 1, 1, 1, 1, 0, 0};
    logic [4:0] t_la  [7] = '{10, 11, 12, 12, 12, 0, 0};
    logic       t_rdy [7] = '{1, 1, 0, 0, 1, 1, 1};
    logic       e_we  [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [4:0] e_a   [7] = '{1, 2, 3, 10, 11, 12, 12};
    logic [31:0] e_d  [7] = '{32'h101, 32'h102, 32'h103, 32'hA, 32'hB, 32'hC, 32'hC};
    logic       e_src [7] = '{0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      ex_we_i = t_ex[i]; ex_waddr_i = t_exa[i];
      ex_wdata_i = 32'h100 + 32'(t_exa[i]);
      lsu_valid_i = t_lv[i]; lsu_waddr_i = t_la[i];
      lsu_wdata_i = (t_la[i] == 0) ? 32'h0 : 32'(t_la[i]);
      #1;
      checks++;
      if (lsu_ready_o !== t_rdy[i]) begin
        errors++;
        $display("FAIL contention_ready[%0d]: ready=%b expected %b", i, lsu_ready_o, t_rdy[i]);
      end
      cyc();
      checks++;
      if (we_a_o !== e_we[i] || waddr_a_o !== e_a[i] || wdata_a_o !== e_d[i]
          || wb_src_o !== e_src[i]) begin
        errors++;
        $display("FAIL contention_write[%0d]: we=%b waddr=%0d wdata=%h src=%b, expected %b %0d %h %b",
                 i, we_a_o, waddr_a_o, wdata_a_o, wb_src_o, e_we[i], e_a[i], e_d[i], e_src[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    issue_load_i = 1; issue_load_addr_i = 9;
    cyc();
    issue_load_i = 0;
    ex_we_i = 1; ex_waddr_i = 9; ex_wdata_i = 32'h99;
    cyc();
    ex_we_i = 0;
    checks++;
    if (busy_o !== 32'h0000_0200 || wb_src_o !== 0) begin
      errors++;
      $display("FAIL sb_ex_no_clear: busy=%h src=%b expected 00000200 0", busy_o, wb_src_o);
    end
    lsu_valid_i = 1; lsu_waddr_i = 9; lsu_wdata_i = 32'h9999;
    issue_load_i = 1; issue_load_addr_i = 9;
    cyc();
    lsu_valid_i = 0; issue_load_i = 0;
    checks++;
    if (busy_o !== 32'h0000_0200 || we_a_o !== 1 || waddr_a_o !== 9 || wb_src_o !== 1) begin
      errors++;
      $display("FAIL sb_set_wins: busy=%h we=%b waddr=%0d src=%b expected 00000200 1 9 1",
               busy_o, we_a_o, waddr_a_o, wb_src_o);
    end
    lsu_valid_i = 1; lsu_wdata_i = 32'h9A9A;
    cyc();
    lsu_valid_i = 0;
    checks++;
    if (busy_o !== 0 || wdata_a_o !== 32'h9A9A) begin
      errors++;
      $display("FAIL sb_clear: busy=%h wdata=%h expected 0 00009a9a", busy_o, wdata_a_o);
    end
    issue_load_i = 1; issue_load_addr_i = 0;
    cyc();
    issue_load_i = 0;
    checks++;
    if (busy_o !== 0) begin
      errors++;
      $display("FAIL sb_x0: busy=%h expected 0", busy_o);
    end
  endtask

  task automatic test_async_reset();
    issue_load_i = 1; issue_load_addr_i = 4;
    ex_we_i = 1; ex_waddr_i = 1; ex_wdata_i = 32'h11;
    lsu_valid_i = 1; lsu_waddr_i = 20; lsu_wdata_i = 32'h20;
    cyc();
    issue_load_i = 0;
    ex_waddr_i = 2; ex_wdata_i = 32'h22;
    lsu_waddr_i = 21; lsu_wdata_i = 32'h21;
    cyc();
    idle_inputs();
    checks++;
    if (lsu_ready_o !== 0 || busy_o !== 32'h0000_0010) begin
      errors++;
      $display("FAIL areset_pre: ready=%b busy=%h expected 0 00000010", lsu_ready_o, busy_o);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (we_a_o !== 0 || busy_o !== 0 || lsu_ready_o !== 1 || waddr_a_o !== 0) begin
      errors++;
      $display("FAIL areset_async: we=%b busy=%h ready=%b waddr=%0d expected 0 0 1 0",
               we_a_o, busy_o, lsu_ready_o, waddr_a_o);
    end
    cyc();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (we_a_o !== 0 || busy_o !== 0 || lsu_ready_o !== 1) begin
        errors++;
        $display("FAIL areset_drain[%0d]: we=%b busy=%h ready=%b expected 0 0 1",
                 i, we_a_o, busy_o, lsu_ready_o);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1;
    #2;
    test_reset();
    test_ex_write();
    test_load_round_trip();
    test_contention();
    test_scoreboard();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
